// File: rtl/mips_bus_pkg.sv
// mips_bus_pkg
//   Shared types for the MIPS instruction/data bus arbiter.
//   state_t : arbiter FSM state. Its encoding is visible on the debug
//             'state' port, so the values are fixed.
//   port_t  : identifies a requesting port (instruction fetch or data).
package mips_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_t;

endpackage

// File: rtl/mips_bus_arbiter.sv
// mips_bus_arbiter
//   Shares one memory bus between the instruction-fetch port and the
//   data port. Each port may have at most one transfer in flight. All bus
//   outputs and acknowledges are registered.
//
//   Parameter
//     DATA_PRIORITY  0 = round-robin on simultaneous requests,
//                    1 = data port always wins simultaneous requests
//   Ports
//     clk, reset                      clock, synchronous active-high reset
//     i_req/i_addr/i_ack/i_rdata      fetch port (always a 4-byte read)
//     d_req/d_we/d_addr/d_wdata/
//     d_byteenable/d_ack/d_rdata      data port
//     address/writedata/read/write/
//     byteenable/waitrequest/readdata memory bus
//     state                           debug view of the FSM state
module mips_bus_arbiter
  import mips_bus_pkg::*;
#(
  parameter int unsigned DATA_PRIORITY = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_byteenable,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic [31:0] address,
  output logic [31:0] writedata,
  output logic        read,
  output logic        write,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic [1:0]  state
);

  state_t cur_state;
  port_t  last_grant;
  port_t  grant;
  logic   i_elig;
  logic   d_elig;

  // A port's request is ignored while its previous ack is still showing,
  // since the requester has not yet had a chance to drop or change it.
  assign i_elig = i_req & ~i_ack;
  assign d_elig = d_req & ~d_ack;

  function automatic port_t arbitrate(input logic  i_e,
                                      input logic  d_e,
                                      input port_t last);
    if (i_e && d_e) begin
      if (DATA_PRIORITY != 0)
        return PORT_D;
      return (last == PORT_D) ? PORT_I : PORT_D;
    end
    return d_e ? PORT_D : PORT_I;
  endfunction

  always_comb grant = arbitrate(i_elig, d_elig, last_grant);

  assign state = cur_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state  <= IDLE;
      last_grant <= PORT_D;  // instruction port wins the first tie
      read       <= 1'b0;
      write      <= 1'b0;
      address    <= '0;
      writedata  <= '0;
      byteenable <= '0;
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      case (cur_state)
        IDLE: begin
          if (i_elig || d_elig) begin
            last_grant <= grant;
            if (grant == PORT_D) begin
              cur_state  <= BUSY_D;
              address    <= d_addr;
              writedata  <= d_wdata;
              byteenable <= d_byteenable;
              read       <= ~d_we;
              write      <= d_we;
            end else begin
              // Fetches leave writedata holding its previous value.
              cur_state  <= BUSY_I;
              address    <= i_addr;
              byteenable <= '1;
              read       <= 1'b1;
              write      <= 1'b0;
            end
          end
        end
        BUSY_I: begin
          if (!waitrequest) begin
            i_rdata   <= readdata;
            i_ack     <= 1'b1;
            read      <= 1'b0;
            cur_state <= IDLE;
          end
        end
        BUSY_D: begin
          if (!waitrequest) begin
            d_rdata   <= readdata;
            d_ack     <= 1'b1;
            read      <= 1'b0;
            write     <= 1'b0;
            cur_state <= IDLE;
          end
        end
        default: cur_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// tb_mips_bus_arbiter
//   Two arbiters: dut (round-robin) with a stalling memory model and a
//   scoreboard, and dut_p (data priority) used for the grant-order check.
module tb_mips_bus_arbiter;

  typedef struct packed {
    logic        we;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_byteenable;
  logic        i_ack, d_ack, read, write, waitrequest;
  logic [31:0] i_rdata, d_rdata, address, writedata, readdata;
  logic [3:0]  byteenable;
  logic [1:0]  state;

  logic        i_req_p, d_req_p, i_ack_p, d_ack_p, read_p, write_p;
  logic [31:0] i_rdata_p, d_rdata_p, address_p, writedata_p;
  logic [3:0]  byteenable_p;
  logic [1:0]  state_p;
  logic        waitrequest_p = 1'b0;
  logic [31:0] readdata_p    = 32'h0;

  mips_bus_arbiter #(.DATA_PRIORITY(0)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_byteenable(d_byteenable), .d_ack(d_ack), .d_rdata(d_rdata),
    .address(address), .writedata(writedata), .read(read), .write(write),
    .byteenable(byteenable), .waitrequest(waitrequest), .readdata(readdata),
    .state(state)
  );

  mips_bus_arbiter #(.DATA_PRIORITY(1)) dut_p (
    .clk(clk), .reset(reset),
    .i_req(i_req_p), .i_addr(i_addr), .i_ack(i_ack_p), .i_rdata(i_rdata_p),
    .d_req(d_req_p), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_byteenable(d_byteenable), .d_ack(d_ack_p), .d_rdata(d_rdata_p),
    .address(address_p), .writedata(writedata_p), .read(read_p), .write(write_p),
    .byteenable(byteenable_p), .waitrequest(waitrequest_p), .readdata(readdata_p),
    .state(state_p)
  );

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory slave and reference memory ----------------
  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  logic        rand_wr  = 1'b0;
  logic        wr_force = 1'b0;

  function automatic logic [31:0] init_word(input int unsigned i);
    return (i * 32'h9E37_79B1) ^ 32'hC001_D00D;
  endfunction

  initial for (int i = 0; i < 256; i++) mem[i] <= init_word(i);

  initial forever begin
    @(posedge clk);
    if (!reset && write && !waitrequest)
      for (int b = 0; b < 4; b++)
        if (byteenable[b]) mem[address[9:2]][8*b +: 8] <= writedata[8*b +: 8];
  end

  initial forever begin
    @(negedge clk);
    waitrequest <= rand_wr ? ($urandom_range(0, 2) == 0) : wr_force;
    readdata    <= mem[address[9:2]];
  end

  // ---------------- scoreboard ----------------
  logic [31:0] i_exp_q [$];
  exp_t        d_exp_q [$];
  logic [31:0] grant_q [$];
  logic [31:0] grant_q_p [$];
  logic [31:0] cur_i_addr = '0, cur_d_addr = '0, cur_d_wdata = '0;
  logic        cur_d_we = 1'b0;
  logic [3:0]  cur_d_be = '0;

  task automatic issue_i(input logic [31:0] a);
    i_addr = a; i_req = 1'b1; cur_i_addr = a;
    i_exp_q.push_back(ref_mem[a[9:2]]);
  endtask

  task automatic issue_d(input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] be);
    exp_t e;
    d_we = we; d_addr = a; d_wdata = wd; d_byteenable = be; d_req = 1'b1;
    cur_d_we = we; cur_d_addr = a; cur_d_wdata = wd; cur_d_be = be;
    if (we) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) ref_mem[a[9:2]][8*b +: 8] = wd[8*b +: 8];
      e.we = 1'b1; e.data = '0;
    end else begin
      e.we = 1'b0; e.data = ref_mem[a[9:2]];
    end
    d_exp_q.push_back(e);
  endtask

  // Monitor: pops expectations on every ack and checks bus transfers.
  initial begin
    logic        prev_strobe, prev_iack, prev_dack, ok;
    logic [31:0] prev_addr, prev_wd, e;
    logic [5:0]  prev_ctl;
    exp_t        de;
    prev_strobe = 1'b0; prev_iack = 1'b0; prev_dack = 1'b0;
    prev_addr = '0; prev_wd = '0; prev_ctl = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_strobe = 1'b0; prev_iack = 1'b0; prev_dack = 1'b0;
      end else begin
        if (i_ack) begin
          check("i_ack_pulse", 32'(prev_iack), 32'd0);
          if (i_exp_q.size() == 0) check("i_ack_expected", 32'(i_exp_q.size()), 32'd1);
          else begin e = i_exp_q.pop_front(); check("i_rdata", i_rdata, e); end
        end
        if (d_ack) begin
          check("d_ack_pulse", 32'(prev_dack), 32'd0);
          if (d_exp_q.size() == 0) check("d_ack_expected", 32'(d_exp_q.size()), 32'd1);
          else begin
            de = d_exp_q.pop_front();
            if (!de.we) check("d_rdata", d_rdata, de.data);
          end
        end
        if (read || write) begin
          check("rd_wr_exclusive", 32'(read & write), 32'd0);
          if (!prev_strobe) begin
            ok = (read && address == cur_i_addr && byteenable == 4'hF) ||
                 (write == cur_d_we && read == !cur_d_we && address == cur_d_addr &&
                  byteenable == cur_d_be && (!cur_d_we || writedata == cur_d_wdata));
            check("bus_tx_match", 32'(ok), 32'd1);
            grant_q.push_back(address);
          end else begin
            check("hold_addr", address, prev_addr);
            check("hold_wdata", writedata, prev_wd);
            check("hold_ctl", {26'b0, byteenable, read, write}, {26'b0, prev_ctl});
          end
        end
        prev_strobe = read | write;
        prev_iack = i_ack; prev_dack = d_ack;
        prev_addr = address; prev_wd = writedata; prev_ctl = {byteenable, read, write};
      end
    end
  end

  initial begin
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) prev = 1'b0;
      else begin
        if ((read_p || write_p) && !prev) grant_q_p.push_back(address_p);
        prev = read_p | write_p;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    i_req = 1'b0; d_req = 1'b0; i_req_p = 1'b0; d_req_p = 1'b0;
    step(); step();
    i_exp_q.delete(); d_exp_q.delete(); grant_q.delete(); grant_q_p.delete();
    reset = 1'b0;
  endtask

  task automatic wait_i();
    int unsigned c = 0;
    while (!i_ack && c < 200) begin step(); c++; end
    if (!i_ack) check("i_ack_timeout", 32'(c), 32'd0);
    i_req = 1'b0;
  endtask

  task automatic wait_d();
    int unsigned c = 0;
    while (!d_ack && c < 200) begin step(); c++; end
    if (!d_ack) check("d_ack_timeout", 32'(c), 32'd0);
    d_req = 1'b0;
  endtask

  task automatic drive_i(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      int unsigned gap = $urandom_range(0, 3);
      for (int unsigned g = 0; g < gap; g++) step();
      issue_i(32'h0040_0000 + (32'($urandom_range(0, 127)) << 2));
      step();
      wait_i();
    end
  endtask

  task automatic drive_d(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      int unsigned gap = $urandom_range(0, 3);
      for (int unsigned g = 0; g < gap; g++) step();
      issue_d(1'($urandom_range(0, 1)), 32'h1000_0200 + (32'($urandom_range(0, 15)) << 2),
              $urandom, 4'($urandom_range(0, 15)));
      step();
      wait_d();
    end
  endtask

  task automatic arb_pair(input logic [31:0] ia, input logic [31:0] da);
    issue_i(ia); issue_d(1'b0, da, 32'h0, 4'hF);
    i_req_p = 1'b1; d_req_p = 1'b1;
    for (int c = 0; c < 30 && (i_req || d_req || i_req_p || d_req_p); c++) begin
      step();
      if (i_ack)   i_req   = 1'b0;
      if (d_ack)   d_req   = 1'b0;
      if (i_ack_p) i_req_p = 1'b0;
      if (d_ack_p) d_req_p = 1'b0;
    end
    check("arb_pair_done", {28'b0, i_req, d_req, i_req_p, d_req_p}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    logic [31:0] exp0 [4];
    logic [31:0] exp1 [4];
    int unsigned wr_cnt, ack_cnt;
    logic        got;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    i_addr = '0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_byteenable = '0;

    // Reset state
    do_reset();
    check("rst_state", 32'(state), 32'd0);
    check("rst_strobes", {30'b0, read, write}, 32'd0);
    check("rst_acks", {30'b0, i_ack, d_ack}, 32'd0);
    check("rst_address", address, 32'd0);
    check("rst_writedata", writedata, 32'd0);
    check("rst_byteenable", 32'(byteenable), 32'd0);
    check("rst_i_rdata", i_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    check("rst_state_p", 32'(state_p), 32'd0);

    // Minimum-latency fetch
    issue_i(32'hBFC0_0000);
    step();
    check("fetch_read_c2", 32'(read), 32'd1);
    check("fetch_addr", address, 32'hBFC0_0000);
    check("fetch_be", 32'(byteenable), 32'hF);
    check("fetch_state", 32'(state), 32'd1);
    check("fetch_no_early_ack", 32'(i_ack), 32'd0);
    step();
    check("fetch_ack_c3", 32'(i_ack), 32'd1);
    check("fetch_read_done", 32'(read), 32'd0);
    i_req = 1'b0;

    // Stalled partial write: waitrequest high for the first three strobe cycles
    wr_force = 1'b1;
    issue_d(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'b0011);
    wr_cnt = 0; ack_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (write) wr_cnt++;
      if (wr_cnt == 4) wr_force = 1'b0;
      if (d_ack) begin ack_cnt++; d_req = 1'b0; end
    end
    check("write_cycles", 32'(wr_cnt), 32'd4);
    check("write_acks", 32'(ack_cnt), 32'd1);
    w = mem[0];
    check("mem_low_half", {16'b0, w[15:0]}, 32'h0000_BEEF);
    check("mem_word", w, ref_mem[0]);

    // Request dropped while the transfer is in flight
    wr_force = 1'b1;
    issue_i(32'h0040_0010);
    step();
    check("drop_busy", 32'(state), 32'd1);
    i_req = 1'b0;
    step(); step();
    wr_force = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 6 && !got; c++) begin step(); got = i_ack; end
    check("drop_still_acked", 32'(got), 32'd1);

    // Simultaneous requests, both arbitration modes
    do_reset();
    arb_pair(32'h0000_0100, 32'h0000_2000);
    arb_pair(32'h0000_0104, 32'h0000_2004);
    exp0[0] = 32'h100;  exp0[1] = 32'h2000; exp0[2] = 32'h104;  exp0[3] = 32'h2004;
    exp1[0] = 32'h2000; exp1[1] = 32'h100;  exp1[2] = 32'h2004; exp1[3] = 32'h104;
    check("rr_grant_count", 32'(grant_q.size()), 32'd4);
    check("pri_grant_count", 32'(grant_q_p.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < grant_q.size())   check("rr_grant_order", grant_q[k], exp0[k]);
      if (k < grant_q_p.size()) check("pri_grant_order", grant_q_p[k], exp1[k]);
    end

    // Reset in the middle of a stalled data transfer
    do_reset();
    wr_force = 1'b1;
    issue_d(1'b0, 32'h1000_0204, 32'h0, 4'hF);
    step();
    check("abort_busy_d", 32'(state), 32'd2);
    step(); step();
    check("abort_read_held", 32'(read), 32'd1);
    reset = 1'b1; d_req = 1'b0;
    step();
    check("abort_strobes", {30'b0, read, write}, 32'd0);
    check("abort_state", 32'(state), 32'd0);
    check("abort_no_ack", 32'(d_ack), 32'd0);
    reset = 1'b0;
    d_exp_q.delete(); i_exp_q.delete();
    wr_force = 1'b0;
    for (int c = 0; c < 3; c++) begin step(); check("abort_no_late_ack", 32'(d_ack), 32'd0); end

    // Randomized concurrent traffic with random stalls
    rand_wr = 1'b1;
    fork
      drive_i(40);
      drive_d(40);
    join
    rand_wr = 1'b0;
    for (int c = 0; c < 5; c++) step();
    check("i_queue_drained", 32'(i_exp_q.size()), 32'd0);
    check("d_queue_drained", 32'(d_exp_q.size()), 32'd0);
    check("final_idle", 32'(state), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
